traffic_monitor: RTL

Passive checker on the receiving end of the TRAFFIC light outputs (Road1/Road2 G/Y/R, Walk G/R). Each clock it samples the eight lamp lines and decodes them per road into a lamp state and globally into a phase. It then checks legality, meaning one-hot lamps, no conflicting greens, legal sequencing and lamp durations, and reports errors and phase changes. It drops in next to TRAFFIC in the bench and in silicon, and drives no lamp.

---
 rtl/traffic_mon_pkg.sv | 44 ++++
 rtl/lamp_tracker.sv | 81 ++++++++
 rtl/traffic_monitor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/traffic_mon_pkg.sv
// Shared types for the traffic light monitor.
// Lamp, phase and error encodings plus the per-road lamp decoder.
package traffic_mon_pkg;

  typedef enum logic [1:0] {
    L_G   = 2'd0,
    L_Y   = 2'd1,
    L_R   = 2'd2,
    L_ILL = 2'd3
  } lamp_e;

  typedef enum logic [2:0] {
    PH_INIT    = 3'd0,
    PH_R1_GO   = 3'd1,
    PH_R2_GO   = 3'd2,
    PH_WALK    = 3'd3,
    PH_ALL_RED = 3'd4,
    PH_BAD     = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    E_NONE     = 3'd0,
    E_ONEHOT   = 3'd1,
    E_CONFLICT = 3'd2,
    E_SEQ      = 3'd3,
    E_YLEN     = 3'd4,
    E_GLEN     = 3'd5,
    E_STUCK    = 3'd6
  } err_e;

  function automatic lamp_e decode_lamp(
    input logic g,
    input logic y,
    input logic r
  );
    case ({g, y, r})
      3'b100:  return L_G;
      3'b010:  return L_Y;
      3'b001:  return L_R;
      default: return L_ILL;
    endcase
  endfunction

endpackage

// File: rtl/lamp_tracker.sv
// Per-road lamp state and duration tracking.
// Flags illegal sequencing, yellow/green length and stuck lamps.
module lamp_tracker
  import traffic_mon_pkg::*;
#(
  parameter int Y_CYC     = 3,
  parameter int G_MIN     = 2,
  parameter int G_MAX     = 40,
  parameter int STUCK_MAX = 64,
  parameter int DW        = $clog2(STUCK_MAX + 1)
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  prev_valid,
  input  lamp_e lamp,
  output logic  seq_err,
  output logic  ylen_err,
  output logic  glen_err,
  output logic  stuck_err,
  output lamp_e cur_state
);

  localparam logic [DW-1:0] YC   = DW'(Y_CYC);
  localparam logic [DW-1:0] GMIN = DW'(G_MIN);
  localparam logic [DW-1:0] GMAX = DW'(G_MAX);
  localparam logic [DW-1:0] SMAX = DW'(STUCK_MAX);

  lamp_e          st_q, st_d;
  logic [DW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           moved, legal;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    seq_err   = 1'b0;
    ylen_err  = 1'b0;
    glen_err  = 1'b0;
    stuck_err = 1'b0;
    cnt_inc   = (cnt_q == SMAX) ? cnt_q : cnt_q + 1'b1;
    // ILL on either side is never a transition
    moved = prev_valid && st_q != L_ILL &&
            lamp != L_ILL && lamp != st_q;
    legal = (st_q == L_G && lamp == L_Y) ||
            (st_q == L_Y && lamp == L_R) ||
            (st_q == L_R && lamp == L_G);
    if (en) begin
      if (lamp == L_ILL) begin
        st_d  = L_ILL;
        cnt_d = '0;
      end else if (lamp != st_q) begin
        st_d  = lamp;
        cnt_d = DW'(1);
      end else begin
        cnt_d = cnt_inc;
      end
      if (moved) begin
        seq_err  = !legal;
        ylen_err = st_q == L_Y && cnt_q != YC;
        glen_err = st_q == L_G && cnt_q < GMIN;
      end else if (prev_valid && lamp == st_q &&
                   st_q == L_G && cnt_q == GMAX) begin
        glen_err = 1'b1;
      end
      stuck_err = cnt_d == SMAX && cnt_q != SMAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= L_ILL;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign cur_state = st_q;

endmodule

// File: rtl/traffic_monitor.sv
// Passive checker for the traffic light lamp outputs.
// Decodes phase, checks legality and keeps sticky error state.
module traffic_monitor
  import traffic_mon_pkg::*;
#(
  parameter int Y_CYC     = 3,
  parameter int G_MIN     = 2,
  parameter int G_MAX     = 40,
  parameter int STUCK_MAX = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             road1_g,
  input  logic             road1_y,
  input  logic             road1_r,
  input  logic             road2_g,
  input  logic             road2_y,
  input  logic             road2_r,
  input  logic             walk_g,
  input  logic             walk_r,
  output logic [2:0]       phase,
  output logic             phase_chg,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       lamps_q, lamps_d;
  logic             en_q, en_d;
  logic             pv_q, pv_d;
  phase_e           phase_q, phase_d, ph;
  logic             chg_q, chg_d;
  logic             err_q, err_d;
  err_e             code_q, code_d, code;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  lamp_e r1, r2, w;
  logic  onehot, conflict, any_err;
  logic  r1_seq, r1_ylen, r1_glen, r1_stuck;
  logic  r2_seq, r2_ylen, r2_glen, r2_stuck;
  lamp_e r1_st_unused, r2_st_unused;

  always_comb begin
    lamps_d = {road1_g, road1_y, road1_r,
               road2_g, road2_y, road2_r,
               walk_g, walk_r};
    en_d    = chk_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lamps_q <= '0;
      en_q    <= 1'b0;
    end else begin
      lamps_q <= lamps_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    r1 = decode_lamp(lamps_q[7], lamps_q[6], lamps_q[5]);
    r2 = decode_lamp(lamps_q[4], lamps_q[3], lamps_q[2]);
    case (lamps_q[1:0])
      2'b10:   w = L_G;
      2'b01:   w = L_R;
      default: w = L_ILL;
    endcase
  end

  lamp_tracker #(
    .Y_CYC(Y_CYC), .G_MIN(G_MIN),
    .G_MAX(G_MAX), .STUCK_MAX(STUCK_MAX)
  ) u_road1 (
    .clk       (clk),
    .rst_n     (rst),
    .en        (en_q),
    .prev_valid(pv_q),
    .lamp      (r1),
    .seq_err   (r1_seq),
    .ylen_err  (r1_ylen),
    .glen_err  (r1_glen),
    .stuck_err (r1_stuck),
    .cur_state (r1_st_unused)
  );

  lamp_tracker #(
    .Y_CYC(Y_CYC), .G_MIN(G_MIN),
    .G_MAX(G_MAX), .STUCK_MAX(STUCK_MAX)
  ) u_road2 (
    .clk       (clk),
    .rst_n     (rst),
    .en        (en_q),
    .prev_valid(pv_q),
    .lamp      (r2),
    .seq_err   (r2_seq),
    .ylen_err  (r2_ylen),
    .glen_err  (r2_glen),
    .stuck_err (r2_stuck),
    .cur_state (r2_st_unused)
  );

  always_comb begin
    onehot   = r1 == L_ILL || r2 == L_ILL || w == L_ILL;
    conflict = (r1 != L_R && r2 != L_R) ||
               (w == L_G && (r1 != L_R || r2 != L_R));
    if ((r1 == L_G || r1 == L_Y) && r2 == L_R && w == L_R)
      ph = PH_R1_GO;
    else if ((r2 == L_G || r2 == L_Y) && r1 == L_R && w == L_R)
      ph = PH_R2_GO;
    else if (r1 == L_R && r2 == L_R && w == L_G)
      ph = PH_WALK;
    else if (r1 == L_R && r2 == L_R && w == L_R)
      ph = PH_ALL_RED;
    else
      ph = PH_BAD;
    // lowest code wins when several checks fire together
    priority case (1'b1)
      onehot:               code = E_ONEHOT;
      conflict:             code = E_CONFLICT;
      r1_seq  || r2_seq:    code = E_SEQ;
      r1_ylen || r2_ylen:   code = E_YLEN;
      r1_glen || r2_glen:   code = E_GLEN;
      r1_stuck || r2_stuck: code = E_STUCK;
      default:              code = E_NONE;
    endcase
    any_err = en_q && code != E_NONE;
  end

  always_comb begin
    phase_d = phase_q;
    chg_d   = 1'b0;
    pv_d    = en_q;
    err_d   = err_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (en_q) begin
      phase_d = ph;
      chg_d   = pv_q && ph != phase_q;
    end
    if (any_err) begin
      err_d = 1'b1;
      if (!err_q)
        code_d = code;
      if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_INIT;
      chg_q   <= 1'b0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      chg_q   <= chg_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase     = phase_q;
  assign phase_chg = chg_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign err_cnt   = cnt_q;

endmodule
